// File: rtl/pingpong_act_ram.sv
// Double-buffered compressed activation RAM: one bank is filled/read while
// the other collects writebacks, and SWAP exchanges their roles.
module pingpong_act_ram #(
    parameter int NUM_CH   = 8,
    parameter int DEPTH    = 64,
    parameter int DW       = 16,
    parameter int IW       = 4,
    parameter int WR_LANES = 4,
    parameter int RD_LANES = 4,
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int OW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int PW = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               cmd,
    input  logic                     stall,
    input  logic [WR_LANES-1:0]      fill_vld,
    input  logic [CW-1:0]            fill_ch,
    input  logic [WR_LANES*DW-1:0]   fill_data,
    input  logic [WR_LANES*IW-1:0]   fill_idx,
    input  logic [WR_LANES-1:0]      wb_vld,
    input  logic [CW-1:0]            wb_ch,
    input  logic [WR_LANES*DW-1:0]   wb_data,
    input  logic [WR_LANES*IW-1:0]   wb_idx,
    input  logic                     rd_en,
    input  logic [CW-1:0]            rd_ch,
    input  logic [OW-1:0]            rd_off,
    output logic                     rd_vld,
    output logic [RD_LANES-1:0]      rd_lane_vld,
    output logic [RD_LANES*DW-1:0]   rd_data,
    output logic [RD_LANES*IW-1:0]   rd_idx,
    output logic [NUM_CH*PW-1:0]     in_cnt,
    output logic                     bank,
    output logic [1:0]               state,
    output logic                     ovf
);

    localparam int SW = PW + $clog2(WR_LANES + 1);
    localparam int RW = PW + $clog2(RD_LANES + 1);
    localparam logic [1:0] C_LOAD = 2'd1;
    localparam logic [1:0] C_RUN  = 2'd2;
    localparam logic [1:0] C_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_SWAP = 2'd3
    } state_t;

    state_t r_state;
    logic   r_bank;
    logic   r_ovf;
    logic [PW-1:0] r_in_ptr  [NUM_CH];
    logic [PW-1:0] r_out_ptr [NUM_CH];
    logic [DW-1:0] r_mem_d [2][NUM_CH][DEPTH];
    logic [IW-1:0] r_mem_i [2][NUM_CH][DEPTH];

    logic                   r_rd_vld;
    logic [RD_LANES-1:0]    r_rd_lv;
    logic [RD_LANES*DW-1:0] r_rd_data;
    logic [RD_LANES*IW-1:0] r_rd_idx;

    logic                   w_wr_load;
    logic                   w_wr_run;
    logic                   w_wr_bank;
    logic [WR_LANES-1:0]    w_wr_vld;
    logic [CW-1:0]          w_wr_ch;
    logic [WR_LANES*DW-1:0] w_wr_data;
    logic [WR_LANES*IW-1:0] w_wr_idx;
    logic [SW-1:0]          w_pos [WR_LANES];
    logic [WR_LANES-1:0]    w_lane_we;
    logic [SW-1:0]          w_sum;
    logic [PW-1:0]          w_new_ptr;
    logic                   w_ovf;

    // Fill (LOAD, input bank) and writeback (RUN, output bank) share one packer.
    always_comb begin
        w_wr_load = !stall && (r_state == S_LOAD);
        w_wr_run  = !stall && (r_state == S_RUN);
        w_wr_bank = w_wr_load ? r_bank : !r_bank;
        w_wr_vld  = w_wr_load ? fill_vld : (w_wr_run ? wb_vld : '0);
        w_wr_ch   = w_wr_load ? fill_ch : wb_ch;
        w_wr_data = w_wr_load ? fill_data : wb_data;
        w_wr_idx  = w_wr_load ? fill_idx : wb_idx;
        w_sum     = w_wr_load ? SW'(r_in_ptr[w_wr_ch]) : SW'(r_out_ptr[w_wr_ch]);
        w_ovf     = 1'b0;
        for (int j = 0; j < WR_LANES; j++) begin
            w_pos[j]     = w_sum;
            w_lane_we[j] = w_wr_vld[j] && (w_pos[j] < SW'(DEPTH));
            w_ovf        = w_ovf | (w_wr_vld[j] && (w_pos[j] >= SW'(DEPTH)));
            w_sum        = w_sum + SW'(w_wr_vld[j]);
        end
        w_new_ptr = (w_sum >= SW'(DEPTH)) ? PW'(DEPTH) : w_sum[PW-1:0];
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < WR_LANES; j++) begin
            if (w_lane_we[j]) begin
                r_mem_d[w_wr_bank][w_wr_ch][w_pos[j][OW-1:0]] <= w_wr_data[j*DW +: DW];
                r_mem_i[w_wr_bank][w_wr_ch][w_pos[j][OW-1:0]] <= w_wr_idx[j*IW +: IW];
            end
        end
    end

    logic                   w_rd_ok;
    logic [RW-1:0]          w_raddr [RD_LANES];
    logic [RD_LANES-1:0]    w_rlv;
    logic [RD_LANES*DW-1:0] w_rdata;
    logic [RD_LANES*IW-1:0] w_ridx;

    always_comb begin
        w_rd_ok = rd_en && ((r_state == S_IDLE) || (r_state == S_RUN));
        w_rlv   = '0;
        w_rdata = '0;
        w_ridx  = '0;
        for (int i = 0; i < RD_LANES; i++) begin
            w_raddr[i] = RW'(rd_off) + RW'(i);
            w_rlv[i]   = w_raddr[i] < RW'(r_in_ptr[rd_ch]);
            if (w_rlv[i]) begin
                w_rdata[i*DW +: DW] = r_mem_d[r_bank][rd_ch][w_raddr[i][OW-1:0]];
                w_ridx[i*IW +: IW]  = r_mem_i[r_bank][rd_ch][w_raddr[i][OW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_bank    <= 1'b0;
            r_ovf     <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_rd_lv   <= '0;
            r_rd_data <= '0;
            r_rd_idx  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_in_ptr[c]  <= '0;
                r_out_ptr[c] <= '0;
            end
        end else if (!stall) begin
            unique case (r_state)
                S_IDLE: begin
                    if (cmd == C_LOAD) begin
                        r_state <= S_LOAD;
                        for (int c = 0; c < NUM_CH; c++) r_in_ptr[c] <= '0;
                    end else if (cmd == C_RUN) begin
                        r_state <= S_RUN;
                        for (int c = 0; c < NUM_CH; c++) r_out_ptr[c] <= '0;
                    end
                end
                S_LOAD: begin
                    if (|w_wr_vld) r_in_ptr[w_wr_ch] <= w_new_ptr;
                    if (cmd == C_DONE) r_state <= S_IDLE;
                end
                S_RUN: begin
                    if (|w_wr_vld) r_out_ptr[w_wr_ch] <= w_new_ptr;
                    if (cmd == C_DONE) r_state <= S_SWAP;
                end
                S_SWAP: begin
                    r_bank  <= !r_bank;
                    r_state <= S_IDLE;
                    for (int c = 0; c < NUM_CH; c++) r_in_ptr[c] <= r_out_ptr[c];
                end
            endcase
            if (w_ovf) r_ovf <= 1'b1;
            r_rd_vld <= w_rd_ok;
            if (w_rd_ok) begin
                r_rd_lv   <= w_rlv;
                r_rd_data <= w_rdata;
                r_rd_idx  <= w_ridx;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) in_cnt[c*PW +: PW] = r_in_ptr[c];
    end

    assign rd_vld      = r_rd_vld;
    assign rd_lane_vld = r_rd_lv;
    assign rd_data     = r_rd_data;
    assign rd_idx      = r_rd_idx;
    assign bank        = r_bank;
    assign state       = r_state;
    assign ovf         = r_ovf;

endmodule

// File: tb/tb_pingpong_act_ram.sv
// Bench for pingpong_act_ram: read responses go through a scoreboard queue,
// control/count behaviour is checked with hand-written sequences.
module tb_pingpong_act_ram;

    localparam int NUM_CH = 4;
    localparam int DEPTH  = 8;
    localparam int DW     = 16;
    localparam int IW     = 4;
    localparam int WL     = 4;
    localparam int RL     = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [1:0]    cmd;
    logic          stall;
    logic [WL-1:0] fill_vld;
    logic [1:0]    fill_ch;
    logic [63:0]   fill_data;
    logic [15:0]   fill_idx;
    logic [WL-1:0] wb_vld;
    logic [1:0]    wb_ch;
    logic [63:0]   wb_data;
    logic [15:0]   wb_idx;
    logic          rd_en;
    logic [1:0]    rd_ch;
    logic [2:0]    rd_off;
    logic          rd_vld;
    logic [RL-1:0] rd_lane_vld;
    logic [63:0]   rd_data;
    logic [15:0]   rd_idx;
    logic [15:0]   in_cnt;
    logic          bank;
    logic [1:0]    state;
    logic          ovf;

    pingpong_act_ram #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .DW(DW), .IW(IW),
        .WR_LANES(WL), .RD_LANES(RL)
    ) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .stall(stall),
        .fill_vld(fill_vld), .fill_ch(fill_ch),
        .fill_data(fill_data), .fill_idx(fill_idx),
        .wb_vld(wb_vld), .wb_ch(wb_ch),
        .wb_data(wb_data), .wb_idx(wb_idx),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_off(rd_off),
        .rd_vld(rd_vld), .rd_lane_vld(rd_lane_vld),
        .rd_data(rd_data), .rd_idx(rd_idx),
        .in_cnt(in_cnt), .bank(bank), .state(state), .ovf(ovf)
    );

    typedef struct packed {
        logic [3:0]  lv;
        logic [63:0] d;
    } exp_t;

    typedef struct {
        logic [1:0]  ch;
        logic [2:0]  off;
        logic [3:0]  lv;
        logic [63:0] d;
    } rv_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic logic [63:0] pk(int l0, int l1, int l2, int l3);
        return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    endfunction

    // Stimulus always uses the low nibble of each data word as its index.
    function automatic logic [15:0] idx_of(logic [63:0] d);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[i*4 +: 4] = d[i*16 +: 4];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] cnt_of(int ch);
        return in_cnt[ch*4 +: 4];
    endfunction

    task automatic drive_fill(input logic [1:0] ch, input logic [3:0] v,
                              input logic [63:0] d);
        fill_ch = ch; fill_vld = v; fill_data = d; fill_idx = idx_of(d);
        @(negedge clk);
        fill_vld = '0;
    endtask

    task automatic drive_wb(input logic [1:0] ch, input logic [3:0] v,
                            input logic [63:0] d);
        wb_ch = ch; wb_vld = v; wb_data = d; wb_idx = idx_of(d);
        @(negedge clk);
        wb_vld = '0;
    endtask

    task automatic cmd_cyc(input logic [1:0] c);
        cmd = c;
        @(negedge clk);
        cmd = 2'd0;
    endtask

    task automatic set_rd(input logic [1:0] ch, input logic [2:0] off,
                          input logic [3:0] lv, input logic [63:0] d,
                          input bit push);
        exp_t e;
        rd_en = 1'b1; rd_ch = ch; rd_off = off;
        if (push) begin
            e.lv = lv;
            e.d  = d;
            q.push_back(e);
        end
    endtask

    task automatic rd_req(input logic [1:0] ch, input logic [2:0] off,
                          input logic [3:0] lv, input logic [63:0] d,
                          input bit push);
        set_rd(ch, off, lv, d, push);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    // A response is due exactly one edge after each queued request.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() == 0) begin
            if (rd_vld) chk("rd_vld_unexpected", {63'd0, rd_vld}, 64'd0);
        end else begin
            e = q.pop_front();
            chk("rd_vld", {63'd0, rd_vld}, 64'd1);
            chk("rd_lane_vld", {60'd0, rd_lane_vld}, {60'd0, e.lv});
            chk("rd_data", rd_data, e.d);
            chk("rd_idx", {48'd0, rd_idx}, {48'd0, idx_of(e.d)});
        end
    end

    rv_t tv[7];

    initial begin
        rst = 1'b0; cmd = 2'd0; stall = 1'b0;
        fill_vld = '0; fill_ch = '0; fill_data = '0; fill_idx = '0;
        wb_vld = '0; wb_ch = '0; wb_data = '0; wb_idx = '0;
        rd_en = 1'b0; rd_ch = '0; rd_off = '0;
        repeat (3) @(negedge clk);
        chk("rst_state", {62'd0, state}, 64'd0);
        chk("rst_bank", {63'd0, bank}, 64'd0);
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
        chk("rst_in_cnt", {48'd0, in_cnt}, 64'd0);
        chk("rst_rd_vld", {63'd0, rd_vld}, 64'd0);
        chk("rst_lane_vld", {60'd0, rd_lane_vld}, 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_rd_idx", {48'd0, rd_idx}, 64'd0);
        rst = 1'b1;

        cmd_cyc(2'd1);
        chk("state_load", {62'd0, state}, 64'd1);
        drive_fill(2'd2, 4'b1011, pk(10, 20, 30, 40));
        chk("cnt2_first", {60'd0, cnt_of(2)}, 64'd3);
        drive_fill(2'd2, 4'b0001, pk(50, 0, 0, 0));
        chk("cnt2_packed", {60'd0, cnt_of(2)}, 64'd4);

        drive_fill(2'd1, 4'b1111, pk(1, 2, 3, 4));
        drive_fill(2'd1, 4'b1111, pk(5, 6, 7, 8));
        chk("ovf_at_full", {63'd0, ovf}, 64'd0);
        chk("cnt1_full", {60'd0, cnt_of(1)}, 64'd8);
        drive_fill(2'd1, 4'b1111, pk(9, 10, 11, 12));
        chk("ovf_set", {63'd0, ovf}, 64'd1);
        chk("cnt1_sat", {60'd0, cnt_of(1)}, 64'd8);

        drive_fill(2'd3, 4'b1111, pk(61, 62, 63, 64));
        drive_fill(2'd3, 4'b0001, pk(65, 0, 0, 0));
        chk("cnt3", {60'd0, cnt_of(3)}, 64'd5);

        rd_req(2'd2, 3'd0, 4'b0000, 64'd0, 1'b0);

        stall = 1'b1; cmd = 2'd3;
        fill_ch = 2'd0; fill_vld = 4'b1111;
        fill_data = pk(1, 1, 1, 1); fill_idx = idx_of(fill_data);
        @(negedge clk);
        chk("stall_state", {62'd0, state}, 64'd1);
        chk("stall_no_write", {60'd0, cnt_of(0)}, 64'd0);
        stall = 1'b0; cmd = 2'd0; fill_vld = '0;

        cmd_cyc(2'd3);
        chk("state_idle", {62'd0, state}, 64'd0);
        drive_fill(2'd0, 4'b1111, pk(1, 1, 1, 1));
        chk("idle_fill_ignored", {60'd0, cnt_of(0)}, 64'd0);
        chk("ovf_sticky", {63'd0, ovf}, 64'd1);

        tv[0] = '{ch: 2'd2, off: 3'd0, lv: 4'b1111, d: pk(10, 20, 40, 50)};
        tv[1] = '{ch: 2'd1, off: 3'd0, lv: 4'b1111, d: pk(1, 2, 3, 4)};
        tv[2] = '{ch: 2'd1, off: 3'd4, lv: 4'b1111, d: pk(5, 6, 7, 8)};
        tv[3] = '{ch: 2'd1, off: 3'd6, lv: 4'b0011, d: pk(7, 8, 0, 0)};
        tv[4] = '{ch: 2'd3, off: 3'd4, lv: 4'b0001, d: pk(65, 0, 0, 0)};
        tv[5] = '{ch: 2'd3, off: 3'd2, lv: 4'b0111, d: pk(63, 64, 65, 0)};
        tv[6] = '{ch: 2'd0, off: 3'd0, lv: 4'b0000, d: pk(0, 0, 0, 0)};
        for (int i = 0; i < 7; i++) begin
            rd_req(tv[i].ch, tv[i].off, tv[i].lv, tv[i].d, 1'b1);
        end
        @(negedge clk);

        chk("bank_before", {63'd0, bank}, 64'd0);
        cmd_cyc(2'd2);
        chk("state_run", {62'd0, state}, 64'd2);
        wb_ch = 2'd0; wb_vld = 4'b0011;
        wb_data = pk(6, 7, 0, 0); wb_idx = idx_of(wb_data);
        fill_ch = 2'd2; fill_vld = 4'b1111;
        fill_data = pk(9, 9, 9, 9); fill_idx = idx_of(fill_data);
        set_rd(2'd2, 3'd0, 4'b1111, pk(10, 20, 40, 50), 1'b1);
        @(negedge clk);
        wb_vld = '0; fill_vld = '0; rd_en = 1'b0;
        chk("run_fill_ignored", {60'd0, cnt_of(2)}, 64'd4);
        drive_wb(2'd1, 4'b0110, pk(99, 11, 22, 99));
        cmd_cyc(2'd3);
        chk("state_swap", {62'd0, state}, 64'd3);
        @(negedge clk);
        chk("state_after_swap", {62'd0, state}, 64'd0);
        chk("bank_toggled", {63'd0, bank}, 64'd1);
        chk("cnt0_swapped", {60'd0, cnt_of(0)}, 64'd2);
        chk("cnt1_swapped", {60'd0, cnt_of(1)}, 64'd2);
        chk("cnt2_swapped", {60'd0, cnt_of(2)}, 64'd0);
        rd_req(2'd0, 3'd0, 4'b0011, pk(6, 7, 0, 0), 1'b1);
        rd_req(2'd1, 3'd0, 4'b0011, pk(11, 22, 0, 0), 1'b1);
        @(negedge clk);

        cmd_cyc(2'd2);
        chk("state_run2", {62'd0, state}, 64'd2);
        drive_wb(2'd0, 4'b1111, pk(1, 2, 3, 4));
        rst = 1'b0; stall = 1'b1; cmd = 2'd1;
        rd_en = 1'b1; rd_ch = 2'd0; rd_off = 3'd0;
        @(negedge clk);
        chk("midrun_rst_state", {62'd0, state}, 64'd0);
        chk("midrun_rst_bank", {63'd0, bank}, 64'd0);
        chk("midrun_rst_ovf", {63'd0, ovf}, 64'd0);
        chk("midrun_rst_cnt", {48'd0, in_cnt}, 64'd0);
        chk("midrun_rst_rd_vld", {63'd0, rd_vld}, 64'd0);
        chk("midrun_rst_lane_vld", {60'd0, rd_lane_vld}, 64'd0);
        chk("midrun_rst_rd_data", rd_data, 64'd0);
        chk("midrun_rst_rd_idx", {48'd0, rd_idx}, 64'd0);
        rst = 1'b1; stall = 1'b0; cmd = 2'd0; rd_en = 1'b0;
        @(negedge clk);
        rd_req(2'd2, 3'd0, 4'b0000, 64'd0, 1'b1);
        @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
